serial_pattern_tx: RTL and testbench
====================================

# serial_pattern_tx

Serial stimulus transmitter for the run-length sequence detector (the block that asserts z after 4 consecutive equal bits on w). It accepts a parallel bit pattern and a repeat count, then shifts the pattern out MSB-first, one bit per clock, onto the detector's w input. In parallel it produces exp_z, the detector output the bench must see, so the board lab and simulation can self-check the detector. It sits between the switch/bench stimulus logic and the detector's w/clock pins.

## Interface
- WIDTH, 16: pattern length in bits (≥2).
- CNT_W, 4: width of repeat count.
- RUN, 4: run length that asserts exp_z (≥2, ≤2^8−1).
- clock  in  1  rising-edge clock shared with the detector.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- pattern  in  WIDTH  bits to send; bit WIDTH−1 first.
- repeats  in  CNT_W  extra passes; total passes = repeats+1.
- w  out  1  serial bit to the detector.
- w_valid  out  1  w carries a transmitted bit this cycle.
- busy  out  1  transmission in progress.
- done  out  1  one-cycle pulse after the last bit.
- exp_z  out  1  expected detector z.

## Operation
- Reset (async, any state): state=IDLE; w, w_valid, busy, done, exp_z all 0; run counter 0.
- States: IDLE, SHIFT, DONE.
- IDLE: start=1 at an edge → latch pattern into shift register and a pattern copy, latch repeats, clear bit counter and run counter, go SHIFT.
- SHIFT: each cycle, w = shift_reg[WIDTH−1], w_valid=1, busy=1; at the edge, shift left by one. After bit WIDTH of a pass: if passes remain, reload shift_reg from the latched copy (no gap cycle) and decrement the pass count; else go DONE.
- DONE: one cycle, done=1, busy=0, w_valid=0; then IDLE.
- start while busy or in DONE: ignored, no queueing. pattern/repeats changes while busy: no effect.
- w outside SHIFT: 0.
- Run tracker: on each transmitted bit, run = 1 if first bit since start or bit ≠ previous bit; else run = min(run+1, RUN). exp_z = (run == RUN), registered.
- Runs continue across pass boundaries (no history clear at reload).
- exp_z holds its last value after DONE until the next accepted start clears it.

## Timing
- start sampled at edge k → bit 1 on w during cycle k+1; bit n during cycle k+n.
- Total bits N = WIDTH·(repeats+1); last bit during cycle k+N; done=1 during k+N+1; IDLE at k+N+2; the earliest new start is sampled at edge k+N+2.
- exp_z rises in the cycle after the RUN-th consecutive equal bit is on w (same latency as the detector's z); it falls in the cycle after the first differing bit.
- busy=1 exactly for cycles k+1 … k+N.

## Structure
- Shared package: state enum (IDLE/SHIFT/DONE), default parameter constants.
- One sub-module: run_tracker (bit, bit_valid, clear → exp_z), reusable as the golden model of the detector.
- Shift register, pass counter, bit counter (width clog2(WIDTH)) and FSM in the top module.

## Test plan
- pattern=16'hF0F0, repeats=0 → w = 1111000011110000 in cycles 1–16; exp_z=1 in cycles 5, 9, 13, 17 (one cycle each, except it holds through 17 until the next start); done at cycle 17.
- pattern=16'h0000, repeats=1 → 32 zeros; exp_z=1 from cycle 5 through the end; done at cycle 33; busy cycles 1–32.
- pattern=16'hAAAA, repeats=3 → alternating bits for 64 cycles; exp_z never 1; done at cycle 65.
- pattern=16'hC003, repeats=1 → zero-run exp_z high in cycles 7–15; ones bits 15–18 span the pass boundary, so exp_z=1 in cycle 19.
- start pulsed again at cycle 5 with a new pattern → ignored, original sequence is unchanged; start in the DONE cycle is also ignored.
- resetn low at cycle 8 mid-SHIFT → w, w_valid, busy, exp_z drop to 0 immediately (async); after release, no bits until a new start.

Source files
------------

// File: rtl/serial_pattern_tx_pkg.sv
// Shared definitions for the serial pattern transmitter and its run tracker.
package serial_pattern_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 4;
  localparam int DEF_RUN   = 4;

endpackage

// File: rtl/serial_pattern_tx_run_tracker.sv
// Golden model of the run-length detector: exp_z goes high one cycle after the
// RUN-th consecutive equal bit and drops one cycle after the first differing bit.
module run_tracker
  import serial_pattern_tx_pkg::*;
#(
  parameter int RUN = DEF_RUN
) (
  input  logic clock,
  input  logic resetn,
  input  logic clear,
  input  logic bit_data,
  input  logic bit_valid,
  output logic exp_z
);

  localparam int RW = $clog2(RUN + 1);

  logic [RW-1:0] run;
  logic [RW-1:0] run_nxt;
  logic          prev;

  // run == 0 marks "no bit seen since the last clear"
  always_comb begin
    run_nxt = run;
    if (run == '0 || bit_data != prev) begin
      run_nxt = RW'(1);
    end else if (run != RW'(RUN)) begin
      run_nxt = run + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      run   <= '0;
      prev  <= 1'b0;
      exp_z <= 1'b0;
    end else if (clear) begin
      run   <= '0;
      exp_z <= 1'b0;
    end else if (bit_valid) begin
      run   <= run_nxt;
      prev  <= bit_data;
      exp_z <= (run_nxt == RW'(RUN));
    end
  end

endmodule

// File: rtl/serial_pattern_tx.sv
// Shifts a parallel pattern out MSB-first (repeats+1 passes, back to back) onto
// the detector's w input while generating the expected detector output exp_z.
module serial_pattern_tx
  import serial_pattern_tx_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int RUN   = DEF_RUN
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] repeats,
  output logic             w,
  output logic             w_valid,
  output logic             busy,
  output logic             done,
  output logic             exp_z
);

  localparam int BW = $clog2(WIDTH);

  state_t           state;
  logic [BW-1:0]    bit_cnt;
  logic [CNT_W-1:0] pass_cnt;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] pat_copy;
  logic             accept;
  logic             pass_end;

  assign accept   = (state == IDLE) && start;
  assign pass_end = (state == SHIFT) && (bit_cnt == BW'(WIDTH - 1));

  // shift_reg holds the bits still to be sent; its MSB is the next bit for w
  always_ff @(posedge clock) begin
    if (accept) begin
      shift_reg <= pattern << 1;
      pat_copy  <= pattern;
    end else if (state == SHIFT) begin
      if (pass_end) begin
        shift_reg <= pat_copy << 1;
      end else begin
        shift_reg <= shift_reg << 1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      pass_cnt <= '0;
      w        <= 1'b0;
      w_valid  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state    <= SHIFT;
            bit_cnt  <= '0;
            pass_cnt <= repeats;
            w        <= pattern[WIDTH-1];
            w_valid  <= 1'b1;
            busy     <= 1'b1;
          end
        end
        SHIFT: begin
          if (pass_end) begin
            bit_cnt <= '0;
            if (pass_cnt != '0) begin
              // reload without a gap cycle
              pass_cnt <= pass_cnt - 1'b1;
              w        <= pat_copy[WIDTH-1];
            end else begin
              state   <= DONE;
              w       <= 1'b0;
              w_valid <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            w       <= shift_reg[WIDTH-1];
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          w       <= 1'b0;
          w_valid <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

  run_tracker #(
    .RUN (RUN)
  ) u_run_tracker (
    .clock     (clock),
    .resetn    (resetn),
    .clear     (accept),
    .bit_data  (w),
    .bit_valid (w_valid),
    .exp_z     (exp_z)
  );

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx: per-cycle comparison of w/w_valid/busy/
// done/exp_z against a sliding-window model, plus hand-derived exp_z points.
module tb_serial_pattern_tx;

  localparam int RUN = 4;

  logic        clock;
  logic        resetn;
  logic        start;
  logic [15:0] pattern;
  logic [3:0]  repeats;
  logic        w;
  logic        w_valid;
  logic        busy;
  logic        done;
  logic        exp_z;

  int checks;
  int errors;
  logic zlog [0:80];

  serial_pattern_tx #(
    .WIDTH (16),
    .CNT_W (4),
    .RUN   (RUN)
  ) dut (
    .clock   (clock),
    .resetn  (resetn),
    .start   (start),
    .pattern (pattern),
    .repeats (repeats),
    .w       (w),
    .w_valid (w_valid),
    .busy    (busy),
    .done    (done),
    .exp_z   (exp_z)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Runs one transmission; cycle c = c-th cycle after the edge that samples start.
  task automatic send(input logic [15:0] pat, input logic [3:0] rep, input bit poke);
    int   n;
    logic s [1:80];
    n = 16 * (int'(rep) + 1);
    for (int i = 1; i <= n; i++) s[i] = pat[15 - ((i - 1) % 16)];
    @(negedge clock);
    start   = 1'b1;
    pattern = pat;
    repeats = rep;
    @(negedge clock);
    start = 1'b0;
    for (int c = 1; c <= n + 2; c++) begin
      int   b;
      logic ez;
      b  = (c - 1 < n) ? c - 1 : n;
      ez = 1'b0;
      if (b >= RUN) begin
        ez = 1'b1;
        for (int j = b - RUN + 1; j <= b; j++) if (s[j] != s[b]) ez = 1'b0;
      end
      check($sformatf("%h w@%0d", pat, c), w, (c <= n) ? s[c] : 1'b0);
      check($sformatf("%h w_valid@%0d", pat, c), w_valid, (c <= n));
      check($sformatf("%h busy@%0d", pat, c), busy, (c <= n));
      check($sformatf("%h done@%0d", pat, c), done, (c == n + 1));
      check($sformatf("%h exp_z@%0d", pat, c), exp_z, ez);
      zlog[c] = exp_z;
      if (poke && c == 5) begin
        start   = 1'b1;
        pattern = ~pat;
        repeats = 4'hF;
      end
      if (poke && c == 6)     start = 1'b0;
      if (poke && c == n + 1) start = 1'b1;
      if (poke && c == n + 2) start = 1'b0;
      if (c < n + 2) @(negedge clock);
    end
  endtask

  initial begin
    int ones;
    checks  = 0;
    errors  = 0;
    resetn  = 1'b0;
    start   = 1'b0;
    pattern = '0;
    repeats = '0;
    repeat (2) @(negedge clock);
    check("rst w", w, 1'b0);
    check("rst w_valid", w_valid, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst exp_z", exp_z, 1'b0);
    resetn = 1'b1;
    repeat (2) @(negedge clock);

    // F0F0 with ignored starts mid-shift and in the DONE cycle
    send(16'hF0F0, 4'd0, 1'b1);
    check("f0 z4", zlog[4], 1'b0);
    check("f0 z5", zlog[5], 1'b1);
    check("f0 z6", zlog[6], 1'b0);
    check("f0 z9", zlog[9], 1'b1);
    check("f0 z13", zlog[13], 1'b1);
    check("f0 z17", zlog[17], 1'b1);

    send(16'h0000, 4'd1, 1'b0);
    check("00 z4", zlog[4], 1'b0);
    check("00 z5", zlog[5], 1'b1);
    check("00 z33", zlog[33], 1'b1);
    check("00 z34", zlog[34], 1'b1);

    send(16'hAAAA, 4'd3, 1'b0);
    ones = 0;
    for (int c = 1; c <= 66; c++) if (zlog[c] === 1'b1) ones++;
    check("aa z_count", ones, 0);

    send(16'hC003, 4'd1, 1'b0);
    check("c0 z6", zlog[6], 1'b0);
    check("c0 z7", zlog[7], 1'b1);
    check("c0 z15", zlog[15], 1'b1);
    check("c0 z16", zlog[16], 1'b0);
    check("c0 z18", zlog[18], 1'b0);
    check("c0 z19", zlog[19], 1'b1);
    check("c0 z20", zlog[20], 1'b0);

    // asynchronous reset in the middle of a pass
    @(negedge clock);
    start   = 1'b1;
    pattern = 16'hFFFF;
    repeats = 4'd0;
    @(negedge clock);
    start = 1'b0;
    repeat (7) @(negedge clock);
    check("pre_rst w", w, 1'b1);
    check("pre_rst exp_z", exp_z, 1'b1);
    resetn = 1'b0;
    #1;
    check("async w", w, 1'b0);
    check("async w_valid", w_valid, 1'b0);
    check("async busy", busy, 1'b0);
    check("async exp_z", exp_z, 1'b0);
    check("async done", done, 1'b0);
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clock);
      check($sformatf("post_rst w_valid@%0d", c), w_valid, 1'b0);
      check($sformatf("post_rst busy@%0d", c), busy, 1'b0);
      check($sformatf("post_rst w@%0d", c), w, 1'b0);
    end

    send(16'hF0F0, 4'd0, 1'b0);
    check("rec z5", zlog[5], 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
